uart_tx_fifo: RTL and testbench

//   Transmit-side byte buffer that sits directly upstream of uart_tx.

---
 rtl/uart_tx_fifo.sv | 74 +++++++
 tb/tb_uart_tx_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding uart_tx through a start/done handshake
module uart_tx_fifo #(
  parameter int W    = 4,
  parameter int DBIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  input  logic            tx_done_tick,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_data,
  output logic            full,
  output logic            empty,
  output logic [W:0]      count,
  output logic            overflow
);
  localparam int DEPTH = 2**W;
  typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;
  state_t          state_q, state_d;
  logic [W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [W:0]      count_q, count_d;
  logic [DBIT-1:0] tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d, overflow_q, overflow_d;
  logic            pop, push;
  logic [DBIT-1:0] mem [DEPTH];
  assign full     = count_q == DEPTH[W:0];
  assign empty    = count_q == '0;
  assign count    = count_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;
  // next state: a pop launches LOAD, LOAD lasts one cycle, BUSY waits for the done tick
  always_comb begin
    pop        = state_q == IDLE && !empty;
    state_d    = pop ? LOAD :
                 state_q == LOAD ? BUSY :
                 (state_q == BUSY && tx_done_tick) ? IDLE : state_q;
    tx_start_d = state_d == LOAD;
  end
  // pointer/occupancy update; a pop frees a slot so a write to a full FIFO still lands
  always_comb begin
    push       = wr && (!full || pop);
    rd_ptr_d   = rd_ptr_q + W'(pop);
    wr_ptr_d   = wr_ptr_q + W'(push);
    count_d    = count_q + (W+1)'(push) - (W+1)'(pop);
    tx_data_d  = pop ? mem[rd_ptr_q] : tx_data_q;
    overflow_d = overflow_q | (wr & !push);
  end
  // control and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
    end
  end
  // storage array, contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= w_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: queue-model and directed checks for uart_tx_fifo
module tb_uart_tx_fifo;
  logic       clk = 0, reset = 0, wr = 0, done_man = 0, done_auto = 0, auto_done = 0;
  logic [7:0] w_data = 0;
  logic       tx_done_tick, tx_start, full, empty, overflow;
  logic [7:0] tx_data;
  logic [4:0] count;
  int         n_pass = 0, n_total = 0, cyc = 0, dcnt = 0;
  logic [7:0] q[$];
  logic [7:0] m_data;
  logic       m_start, m_idle, m_ovf, pop;
  logic [7:0] log_d[$];
  int         log_c[$];

  assign tx_done_tick = done_man | done_auto;

  uart_tx_fifo #(.W(4), .DBIT(8)) dut (
    .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .tx_done_tick(tx_done_tick),
    .tx_start(tx_start), .tx_data(tx_data), .full(full), .empty(empty),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_start = 0; m_data = 0; m_idle = 1; m_ovf = 0;
    end else begin
      pop = m_idle && q.size() > 0;
      if (!m_idle && !m_start && tx_done_tick) m_idle = 1;
      if (pop) begin
        m_data = q.pop_front();
        m_idle = 0;
      end
      if (wr) begin
        if (q.size() < 16) q.push_back(w_data);
        else m_ovf = 1;
      end
      m_start = pop;
    end
  end

  always @(negedge clk)
    if (!reset)
      check("model", {15'd0, tx_start, tx_data, count, full, empty, overflow},
            {15'd0, m_start, m_data, 5'(q.size()), q.size() == 16, q.size() == 0, m_ovf});

  always @(negedge clk)
    if (!reset && tx_start) begin
      log_d.push_back(tx_data);
      log_c.push_back(cyc);
    end

  always @(negedge clk) begin
    if (reset || !auto_done) begin
      dcnt = 0; done_auto = 0;
    end else if (m_start) begin
      dcnt = 20; done_auto = 0;
    end else if (dcnt != 0) begin
      dcnt--; done_auto = dcnt == 0;
    end else done_auto = 0;
  end

  task automatic wait_log(int n, int limit);
    for (int i = 0; i < limit && log_d.size() < n; i++) @(negedge clk);
  endtask

  initial begin
    #3 reset = 1;
    #1 check("reset_count", count, 0);
    check("reset_flags", {tx_start, full, empty, overflow}, 4'b0010);
    check("reset_data", tx_data, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk); wr = 1; w_data = 8'hA5;
    @(negedge clk); wr = 0;
    check("t1_count1", count, 1);
    check("t1_nostart", tx_start, 0);
    @(negedge clk);
    check("t1_start", tx_start, 1);
    check("t1_data", tx_data, 8'hA5);
    check("t1_empty", {empty, count}, {1'b1, 5'd0});
    @(negedge clk);
    check("t1_pulse_end", tx_start, 0);
    done_man = 1;
    @(negedge clk); done_man = 0;
    repeat (3) @(negedge clk);
    log_d.delete(); log_c.delete();
    auto_done = 1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); wr = 1; w_data = 8'(i);
    end
    @(negedge clk); wr = 0;
    wait_log(5, 400);
    check("t2_n", log_d.size(), 5);
    for (int i = 0; i < 5 && i < log_d.size(); i++) check("t2_byte", log_d[i], i + 1);
    for (int i = 1; i < 5 && i < log_c.size(); i++) check("t2_gap", log_c[i] - log_c[i-1], 22);
    repeat (30) @(negedge clk);
    auto_done = 0;
    log_d.delete(); log_c.delete();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); wr = 1; w_data = 8'h10 + 8'(i);
    end
    @(negedge clk); w_data = 8'h99;
    check("t3_full", {full, count}, {1'b1, 5'd16});
    check("t3_ovf_before", overflow, 0);
    @(negedge clk); wr = 0;
    check("t3_drop_count", count, 16);
    check("t3_ovf", overflow, 1);
    auto_done = 1; done_man = 1;
    @(negedge clk); done_man = 0; wr = 1; w_data = 8'h7E;
    @(negedge clk); wr = 0;
    check("t4_count", {full, count}, {1'b1, 5'd16});
    check("t4_start", {tx_start, tx_data}, {1'b1, 8'h11});
    wait_log(18, 600);
    check("t4_n", log_d.size(), 18);
    if (log_d.size() == 18) begin
      check("t4_second_last", log_d[16], 8'h20);
      check("t4_last", log_d[17], 8'h7E);
    end
    check("t4_ovf_sticky", overflow, 1);
    repeat (25) @(negedge clk);
    log_d.delete(); log_c.delete();
    for (int i = 0, t = 0; i < 40 && t < 3000; t++) begin
      @(negedge clk);
      if (q.size() < 16) begin
        wr = 1; w_data = 8'(i); i++;
      end else wr = 0;
    end
    @(negedge clk); wr = 0;
    wait_log(40, 1200);
    check("t5_n", log_d.size(), 40);
    for (int i = 0; i < 40 && i < log_d.size(); i++) check("t5_order", log_d[i], i);
    repeat (25) @(negedge clk);
    auto_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr = 1; w_data = 8'hC0 + 8'(i);
    end
    @(negedge clk); wr = 0;
    repeat (2) @(negedge clk);
    check("t6_pre_count", count, 3);
    check("t6_pre_ovf", overflow, 1);
    reset = 1;
    #1 check("t6_rst_start", tx_start, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_flags", {empty, overflow, tx_data}, {1'b1, 1'b0, 8'h00});
    @(negedge clk);
    reset = 0;
    log_d.delete(); log_c.delete();
    repeat (30) @(negedge clk);
    check("t6_no_start", log_d.size(), 0);
    check("t6_idle", {empty, count}, {1'b1, 5'd0});
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
